// File: rtl/crtc_reg_loader.sv
// Loads a range of 6845 CRTC registers from a synchronous table, with optional readback check.
// Latency: 4 CLKEN steps per register (6 with readback) plus 2 (accept + finish); outputs registered.
// Backpressure: none; pacing is set only by CLKEN, and start is ignored while busy.
//
// Ports:
//   CLOCK, nRESET        : clock, asynchronous active-low reset
//   CLKEN                : step enable; state and outputs advance only on CLKEN edges
//   start/first_reg/last_reg/verify : load request and its parameters, latched on accept
//   tbl_addr/tbl_data    : synchronous table port (data valid one step after the address)
//   busy/done/err/err_reg: status; done is a single-CLOCK pulse, err is sticky until the next start
//   crtc_*               : 6845 bus (EN, nCS, R_nW, RS, DI out; DO in)
module crtc_reg_loader (
  input  logic       CLOCK,
  input  logic       nRESET,
  input  logic       CLKEN,
  input  logic       start,
  input  logic [3:0] first_reg,
  input  logic [3:0] last_reg,
  input  logic       verify,
  output logic [3:0] tbl_addr,
  input  logic [7:0] tbl_data,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [3:0] err_reg,
  output logic       crtc_en,
  output logic       crtc_ncs,
  output logic       crtc_rnw,
  output logic       crtc_rs,
  output logic [7:0] crtc_di,
  input  logic [7:0] crtc_do
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_SEL   = 3'd2,
    S_WR    = 3'd3,
    S_RSEL  = 3'd4,
    S_RD    = 3'd5,
    S_NEXT  = 3'd6,
    S_FIN   = 3'd7
  } state_t;

  // Bits of each readable register that the CRTC actually stores.
  function automatic logic [7:0] rd_mask(input logic [3:0] r);
    case (r)
      4'd10:   rd_mask = 8'h7F;
      4'd11:   rd_mask = 8'h1F;
      4'd14:   rd_mask = 8'h3F;
      default: rd_mask = 8'hFF;
    endcase
  endfunction

  state_t     r_state;
  logic [3:0] r_cur;
  logic [3:0] r_last;
  logic       r_verify;
  logic [7:0] r_exp;
  logic       r_busy;
  logic       r_done;
  logic       r_err;
  logic [3:0] r_err_reg;
  logic [3:0] r_tbl_addr;
  logic       r_en;
  logic       r_ncs;
  logic       r_rnw;
  logic       r_rs;
  logic [7:0] r_di;

  state_t     w_next;
  logic [3:0] w_cur;
  logic [3:0] w_last;
  logic       w_verify;
  logic [7:0] w_exp;
  logic       w_busy;
  logic       w_err;
  logic [3:0] w_err_reg;
  logic [3:0] w_tbl_addr;
  logic       w_en;
  logic       w_ncs;
  logic       w_rnw;
  logic       w_rs;
  logic [7:0] w_di;
  logic       w_readable;
  logic [7:0] w_mask;
  logic       w_mismatch;

  assign w_readable = (r_cur == 4'd10) || (r_cur == 4'd11) ||
                      (r_cur == 4'd14) || (r_cur == 4'd15);
  assign w_mask     = rd_mask(r_cur);
  assign w_mismatch = (crtc_do & w_mask) != (r_exp & w_mask);

  always_comb begin
    w_next     = r_state;
    w_cur      = r_cur;
    w_last     = r_last;
    w_verify   = r_verify;
    w_exp      = r_exp;
    w_busy     = r_busy;
    w_err      = r_err;
    w_err_reg  = r_err_reg;
    w_tbl_addr = r_tbl_addr;
    w_en       = 1'b0;
    w_ncs      = 1'b1;
    w_rnw      = 1'b1;
    w_rs       = 1'b0;
    w_di       = r_di;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_cur     = first_reg;
          w_last    = last_reg;
          w_verify  = verify;
          w_busy    = 1'b1;
          w_err     = 1'b0;
          w_err_reg = 4'd0;
          w_next    = (first_reg > last_reg) ? S_FIN : S_FETCH;
        end
      end
      S_FETCH: w_next = S_SEL;
      S_SEL:   w_next = S_WR;
      S_WR:    w_next = (r_verify && w_readable) ? S_RSEL : S_NEXT;
      S_RSEL:  w_next = S_RD;
      S_RD: begin
        // crtc_do is valid while the read cycle is on the bus, i.e. in this state.
        if (w_mismatch) begin
          w_err = 1'b1;
          if (!r_err) w_err_reg = r_cur;
        end
        w_next = S_NEXT;
      end
      S_NEXT: begin
        if (r_cur == r_last) begin
          w_next = S_FIN;
        end else begin
          w_cur  = r_cur + 4'd1;
          w_next = S_FETCH;
        end
      end
      S_FIN: begin
        w_busy = 1'b0;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase

    // Bus and table outputs are registered with the values of the state being
    // entered, so each bus phase is stable for the whole of its state.
    case (w_next)
      S_FETCH: w_tbl_addr = w_cur;
      S_SEL: begin
        w_en = 1'b1; w_ncs = 1'b0; w_rnw = 1'b0; w_rs = 1'b0;
        w_di = {4'b0000, w_cur};
      end
      S_WR: begin
        w_en = 1'b1; w_ncs = 1'b0; w_rnw = 1'b0; w_rs = 1'b1;
        w_di  = tbl_data;
        w_exp = tbl_data;
      end
      S_RSEL: begin
        w_en = 1'b1; w_ncs = 1'b0; w_rnw = 1'b0; w_rs = 1'b0;
        w_di = {4'b0000, w_cur};
      end
      S_RD: begin
        w_en = 1'b1; w_ncs = 1'b0; w_rnw = 1'b1; w_rs = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK or negedge nRESET) begin
    if (!nRESET) begin
      r_state    <= S_IDLE;
      r_cur      <= 4'd0;
      r_last     <= 4'd0;
      r_verify   <= 1'b0;
      r_exp      <= 8'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_reg  <= 4'd0;
      r_tbl_addr <= 4'd0;
      r_en       <= 1'b0;
      r_ncs      <= 1'b1;
      r_rnw      <= 1'b1;
      r_rs       <= 1'b0;
      r_di       <= 8'd0;
    end else begin
      // done is not held by CLKEN: it lasts exactly one CLOCK.
      r_done <= CLKEN && (r_state == S_FIN);
      if (CLKEN) begin
        r_state    <= w_next;
        r_cur      <= w_cur;
        r_last     <= w_last;
        r_verify   <= w_verify;
        r_exp      <= w_exp;
        r_busy     <= w_busy;
        r_err      <= w_err;
        r_err_reg  <= w_err_reg;
        r_tbl_addr <= w_tbl_addr;
        r_en       <= w_en;
        r_ncs      <= w_ncs;
        r_rnw      <= w_rnw;
        r_rs       <= w_rs;
        r_di       <= w_di;
      end
    end
  end

  assign tbl_addr = r_tbl_addr;
  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;
  assign err_reg  = r_err_reg;
  assign crtc_en  = r_en;
  assign crtc_ncs = r_ncs;
  assign crtc_rnw = r_rnw;
  assign crtc_rs  = r_rs;
  assign crtc_di  = r_di;

endmodule

// File: tb/tb_crtc_reg_loader.sv
// Bench for crtc_reg_loader: table ROM and 6845 register model attached, directed plus random loads.
// Latency: checks step counts and CLOCK counts against a reference model of the load sequence.
// Backpressure: CLKEN is a periodic 1-in-div enable, div varied per run.
module tb_crtc_reg_loader;

  logic       CLOCK = 1'b0;
  logic       nRESET;
  logic       CLKEN = 1'b0;
  logic       start;
  logic [3:0] first_reg;
  logic [3:0] last_reg;
  logic       verify;
  logic [3:0] tbl_addr;
  logic [7:0] tbl_data = 8'h00;
  logic       busy;
  logic       done;
  logic       err;
  logic [3:0] err_reg;
  logic       crtc_en;
  logic       crtc_ncs;
  logic       crtc_rnw;
  logic       crtc_rs;
  logic [7:0] crtc_di;
  logic [7:0] crtc_do;

  int total = 0;
  int bad   = 0;

  crtc_reg_loader dut (
    .CLOCK(CLOCK), .nRESET(nRESET), .CLKEN(CLKEN), .start(start),
    .first_reg(first_reg), .last_reg(last_reg), .verify(verify),
    .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .busy(busy), .done(done), .err(err), .err_reg(err_reg),
    .crtc_en(crtc_en), .crtc_ncs(crtc_ncs), .crtc_rnw(crtc_rnw),
    .crtc_rs(crtc_rs), .crtc_di(crtc_di), .crtc_do(crtc_do)
  );

  always #5 CLOCK = ~CLOCK;

  // Periodic step enable, one CLOCK in div.
  int div  = 1;
  int ccnt = 0;
  always @(negedge CLOCK) begin
    ccnt  = (ccnt + 1 >= div) ? 0 : ccnt + 1;
    CLKEN = (ccnt == 0);
  end

  // Synchronous table, clocked on steps.
  logic [7:0] tbl [16];
  always @(posedge CLOCK) if (CLKEN) tbl_data <= tbl[tbl_addr];

  // Width of each register as stored by a 6845 (readback returns only these bits).
  function automatic logic [7:0] mask_of(input int r);
    case (r)
      10:      mask_of = 8'h7F;
      11:      mask_of = 8'h1F;
      14:      mask_of = 8'h3F;
      default: mask_of = 8'hFF;
    endcase
  endfunction

  // CRTC model: address register plus 16 data registers.
  logic [7:0]  creg [16];
  logic [4:0]  caddr  = 5'd0;
  int          wr_cnt = 0;
  logic        mem_clr = 1'b0;
  logic [15:0] force0 = 16'h0;
  always @(posedge CLOCK) begin
    if (mem_clr) begin
      for (int i = 0; i < 16; i++) creg[i] <= 8'h5A;
      caddr  <= 5'd0;
      wr_cnt <= 0;
    end else if (CLKEN && crtc_en && !crtc_ncs && !crtc_rnw) begin
      if (!crtc_rs) caddr <= crtc_di[4:0];
      else begin
        creg[caddr[3:0]] <= crtc_di;
        wr_cnt <= wr_cnt + 1;
      end
    end
  end
  assign crtc_do = force0[caddr[3:0]] ? 8'h00
                 : (creg[caddr[3:0]] & mask_of(int'(caddr[3:0])));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: what a load of registers f..l should cost and report.
  task automatic model(input int f, input int l, input bit v,
                       output int steps, output int writes, output bit e, output int ereg);
    steps = 2; writes = 0; e = 1'b0; ereg = 0;
    if (f <= l) begin
      for (int r = f; r <= l; r++) begin
        writes++;
        if (v && (r == 10 || r == 11 || r == 14 || r == 15)) begin
          steps += 6;
          // Readback returns tbl&mask unless forced to zero.
          if (force0[r] && ((tbl[r] & mask_of(r)) != 8'h00)) begin
            if (!e) ereg = r;
            e = 1'b1;
          end
        end else begin
          steps += 4;
        end
      end
    end
  endtask

  task automatic do_run(input string tag, input int f, input int l, input bit v,
                        input int poke, output int steps_o);
    int  steps, clocks, dones;
    bit  fin;
    int  m_steps, m_writes, m_ereg;
    bit  m_err;
    @(negedge CLOCK); mem_clr = 1'b1;
    @(negedge CLOCK); mem_clr = 1'b0;
    first_reg = f[3:0]; last_reg = l[3:0]; verify = v; start = 1'b1;
    steps = 0; clocks = 0; dones = 0; fin = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge CLOCK);
      if (CLKEN) begin steps = 1; break; end
    end
    @(negedge CLOCK); start = 1'b0;
    for (int i = 0; i < 5000 && !fin; i++) begin
      @(posedge CLOCK);
      clocks++;
      if (CLKEN) steps++;
      #1;
      if (done) begin dones++; fin = 1'b1; end
      if (poke != 0 && steps == poke) start = 1'b1;
      if (poke != 0 && steps == poke + 1) start = 1'b0;
    end
    start = 1'b0;
    check({tag, "_finished"}, fin, 1'b1);
    model(f, l, v, m_steps, m_writes, m_err, m_ereg);
    check({tag, "_steps"}, steps, m_steps);
    check({tag, "_clocks"}, clocks, (m_steps - 1) * div);
    check({tag, "_busy_at_done"}, busy, 1'b0);
    check({tag, "_err"}, err, m_err);
    check({tag, "_err_reg"}, err_reg, m_ereg);
    @(posedge CLOCK); #1;
    check({tag, "_done_width"}, done, 1'b0);
    check({tag, "_writes"}, wr_cnt, m_writes);
    for (int r = 0; r < 16; r++)
      check($sformatf("%s_R%0d", tag, r), creg[r],
            (f <= l && r >= f && r <= l) ? tbl[r] : 8'h5A);
    repeat (3 * div) @(posedge CLOCK);
    #1;
    check({tag, "_idle_after"}, busy, 1'b0);
    steps_o = steps;
  endtask

  initial begin
    int st;
    bit seen;
    nRESET = 1'b0; start = 1'b0; first_reg = 4'd0; last_reg = 4'd0; verify = 1'b0;
    for (int i = 0; i < 16; i++) tbl[i] = i[7:0];
    #12;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_err_reg", err_reg, 4'd0);
    check("rst_tbl_addr", tbl_addr, 4'd0);
    check("rst_en", crtc_en, 1'b0);
    check("rst_ncs", crtc_ncs, 1'b1);
    check("rst_rnw", crtc_rnw, 1'b1);
    check("rst_rs", crtc_rs, 1'b0);
    check("rst_di", crtc_di, 8'h00);
    @(negedge CLOCK); nRESET = 1'b1;

    // Reset in the middle of a data write.
    @(negedge CLOCK); first_reg = 4'd0; last_reg = 4'd15; verify = 1'b0; start = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge CLOCK); #1;
      if (busy) start = 1'b0;
      if (crtc_en && !crtc_ncs && !crtc_rnw && crtc_rs) seen = 1'b1;
    end
    check("mid_wr_reached", seen, 1'b1);
    #2 nRESET = 1'b0;
    #1;
    check("mid_rst_en", crtc_en, 1'b0);
    check("mid_rst_ncs", crtc_ncs, 1'b1);
    check("mid_rst_rnw", crtc_rnw, 1'b1);
    check("mid_rst_busy", busy, 1'b0);
    start = 1'b0;
    @(negedge CLOCK); nRESET = 1'b1;

    // Full range, no readback.
    do_run("full", 0, 15, 1'b0, 0, st);
    check("full_steps66", st, 66);

    // Cursor registers with readback.
    tbl[12] = 8'h3C; tbl[13] = 8'h81; tbl[14] = 8'hFF; tbl[15] = 8'hA5;
    do_run("vfy", 12, 15, 1'b1, 0, st);
    check("vfy_steps22", st, 22);

    // R15 reads back as zero.
    force0 = 16'h8000;
    do_run("vfy_bad", 12, 15, 1'b1, 0, st);
    check("vfy_bad_err", err, 1'b1);
    check("vfy_bad_reg", err_reg, 4'd15);
    force0 = 16'h0000;

    // Empty range.
    do_run("empty", 9, 3, 1'b0, 0, st);
    check("empty_steps2", st, 2);

    // Slow steps and a second start while busy.
    div = 4;
    for (int i = 0; i < 16; i++) tbl[i] = 8'hC0 + i[7:0];
    do_run("slow", 0, 3, 1'b0, 3, st);
    check("slow_steps18", st, 18);

    // Random loads.
    for (int k = 0; k < 8; k++) begin
      div = $urandom_range(1, 3);
      for (int i = 0; i < 16; i++) tbl[i] = 8'($urandom);
      force0 = 16'($urandom);
      do_run($sformatf("rnd%0d", k), $urandom_range(0, 15), $urandom_range(0, 15),
             1'($urandom), 0, st);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
